csr_trap_ctrl: RTL and testbench

Sequencer and arbiter in front of the machine-mode CSR register file (mstatus 0x300, mie 0x304, mepc 0x341, mip 0x344).
- Shares the file's single read/write port between pipeline CSR instructions and its own trap/mret sequences.
- Sequences interrupt entry (check enables, save mepc, update mstatus/mip, redirect to vector) and mret return (restore mstatus, redirect to mepc).
- Sits between the decode/execute stage and the CSR file, and drives stall, flush and redirect to the fetch unit.

---
 rtl/csr_trap_ctrl_if.sv | 31 +++
 rtl/csr_trap_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_trap_ctrl_if.sv
// Pipeline CSR access port and CSR register-file port of the trap controller.
// The controller is the slave of the pipeline side and drives the file side.
interface csr_trap_ctrl_if;
  // pipeline side
  logic        pl_req;
  logic        pl_wr;
  logic [11:0] pl_addr;
  logic [31:0] pl_wdata;
  logic        pl_gnt;
  logic [31:0] pl_rdata;
  // CSR register file side
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_rd;
  logic        csr_wr;
  logic [31:0] csr_rdata;

  modport slave (
    input  pl_req, pl_wr, pl_addr, pl_wdata,
    output pl_gnt, pl_rdata,
    output csr_addr, csr_wdata, csr_rd, csr_wr,
    input  csr_rdata
  );

  modport master (
    output pl_req, pl_wr, pl_addr, pl_wdata,
    input  pl_gnt, pl_rdata,
    input  csr_addr, csr_wdata, csr_rd, csr_wr,
    output csr_rdata
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR port arbiter plus interrupt-entry / mret sequencer.
// IDLE hands the single CSR port to the pipeline; trap and mret sequences
// own the port one access per cycle and end with a flush + redirect.
module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC_BASE = 32'h0000_0100,
  parameter logic [31:0] CAUSE_EXT  = 32'h8000_000B,
  parameter logic [31:0] CAUSE_TMR  = 32'h8000_0007
) (
  input  logic                clk,
  input  logic                rst,
  csr_trap_ctrl_if.slave      bus,
  input  logic                i_ext_irq,
  input  logic                i_timer_irq,
  input  logic                i_mret,
  input  logic [31:0]         i_pc,
  output logic                o_busy,
  output logic                o_flush,
  output logic                o_redirect,
  output logic [31:0]         o_redirect_pc,
  output logic [31:0]         o_trap_cause
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MIP     = 12'h344;

  typedef enum logic [3:0] {
    S_IDLE, S_CHK_ST, S_CHK_IE, S_WR_EPC, S_WR_ST, S_WR_IP, S_REDIR,
    S_M_RD_ST, S_M_WR_ST, S_M_RD_EPC
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_epc, r_st, r_cause, r_redirect_pc;
  logic        r_irq_ext, r_irq_tmr, r_take_ext, r_masked;
  logic        r_ext_prev, r_tmr_prev;

  logic        w_gnt, w_start, w_take, w_rise, w_clr_mask;
  logic        w_busy, w_flush, w_redirect;
  logic [11:0] w_csr_addr;
  logic [31:0] w_csr_wdata, w_pl_rdata;
  logic        w_csr_rd, w_csr_wr;

  // mret beats the pipeline, the pipeline beats a new interrupt
  assign w_gnt   = (r_state == S_IDLE) & bus.pl_req & ~i_mret;
  assign w_start = (r_state == S_IDLE) & (i_ext_irq | i_timer_irq) & ~r_masked
                   & ~i_mret & ~bus.pl_req;
  // only meaningful in CHK_IE, where csr_rdata carries mie
  assign w_take  = r_st[3] & ((r_irq_ext & bus.csr_rdata[11]) |
                              (r_irq_tmr & bus.csr_rdata[7]));
  assign w_rise  = (i_ext_irq & ~r_ext_prev) | (i_timer_irq & ~r_tmr_prev);
  // software touching mstatus/mie may have made a pending irq takeable
  assign w_clr_mask = w_rise |
                      (w_gnt & bus.pl_wr & ((bus.pl_addr == A_MSTATUS) | (bus.pl_addr == A_MIE)));

  // next state and all port-level outputs
  always_comb begin
    w_next      = r_state;
    w_csr_addr  = '0;
    w_csr_wdata = '0;
    w_csr_rd    = 1'b0;
    w_csr_wr    = 1'b0;
    w_pl_rdata  = '0;
    w_busy      = 1'b1;
    w_flush     = 1'b0;
    w_redirect  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (i_mret) begin
          w_next = S_M_RD_ST;
        end else if (bus.pl_req) begin
          w_csr_addr  = bus.pl_addr;
          w_csr_wdata = bus.pl_wdata;
          w_csr_rd    = ~bus.pl_wr;
          w_csr_wr    = bus.pl_wr;
          w_pl_rdata  = bus.csr_rdata;
        end else if (w_start) begin
          w_next = S_CHK_ST;
        end
      end
      S_CHK_ST: begin
        w_csr_addr = A_MSTATUS;
        w_csr_rd   = 1'b1;
        w_next     = S_CHK_IE;
      end
      S_CHK_IE: begin
        w_csr_addr = A_MIE;
        w_csr_rd   = 1'b1;
        w_next     = w_take ? S_WR_EPC : S_IDLE;
      end
      S_WR_EPC: begin
        w_csr_addr  = A_MEPC;
        w_csr_wdata = r_epc;
        w_csr_wr    = 1'b1;
        w_next      = S_WR_ST;
      end
      S_WR_ST: begin
        // MPIE <= MIE, MIE <= 0
        w_csr_addr  = A_MSTATUS;
        w_csr_wdata = {r_st[31:8], r_st[3], r_st[6:4], 1'b0, r_st[2:0]};
        w_csr_wr    = 1'b1;
        w_next      = S_WR_IP;
      end
      S_WR_IP: begin
        w_csr_addr  = A_MIP;
        w_csr_rd    = 1'b1;
        w_csr_wr    = 1'b1;
        w_csr_wdata = bus.csr_rdata | (r_take_ext ? 32'h0000_0800 : 32'h0000_0080);
        w_next      = S_REDIR;
      end
      S_REDIR: begin
        w_flush    = 1'b1;
        w_redirect = 1'b1;
        w_next     = S_IDLE;
      end
      S_M_RD_ST: begin
        w_csr_addr = A_MSTATUS;
        w_csr_rd   = 1'b1;
        w_next     = S_M_WR_ST;
      end
      S_M_WR_ST: begin
        // MIE <= MPIE, MPIE <= 1
        w_csr_addr  = A_MSTATUS;
        w_csr_wdata = {r_st[31:8], 1'b1, r_st[6:4], r_st[7], r_st[2:0]};
        w_csr_wr    = 1'b1;
        w_next      = S_M_RD_EPC;
      end
      S_M_RD_EPC: begin
        w_csr_addr = A_MEPC;
        w_csr_rd   = 1'b1;
        w_next     = S_REDIR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // state register plus the values each sequence step latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_epc         <= '0;
      r_st          <= '0;
      r_cause       <= '0;
      r_redirect_pc <= '0;
      r_irq_ext     <= 1'b0;
      r_irq_tmr     <= 1'b0;
      r_take_ext    <= 1'b0;
      r_masked      <= 1'b0;
      r_ext_prev    <= 1'b0;
      r_tmr_prev    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ext_prev <= i_ext_irq;
      r_tmr_prev <= i_timer_irq;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_epc     <= i_pc;
          r_irq_ext <= i_ext_irq;
          r_irq_tmr <= i_timer_irq;
        end
        S_CHK_ST:   r_st <= bus.csr_rdata;
        S_CHK_IE: begin
          r_take_ext <= r_irq_ext & bus.csr_rdata[11];
          if (!w_take) r_masked <= 1'b1;
        end
        S_WR_IP: begin
          r_cause       <= r_take_ext ? CAUSE_EXT : CAUSE_TMR;
          r_redirect_pc <= MTVEC_BASE;
        end
        S_REDIR:    r_masked <= 1'b0;
        S_M_RD_ST:  r_st <= bus.csr_rdata;
        S_M_RD_EPC: r_redirect_pc <= bus.csr_rdata;
        default: ;
      endcase
      // a fresh edge or a config write re-arms polling even mid-check
      if (w_clr_mask) r_masked <= 1'b0;
    end
  end

  assign bus.pl_gnt    = w_gnt;
  assign bus.pl_rdata  = w_pl_rdata;
  assign bus.csr_addr  = w_csr_addr;
  assign bus.csr_wdata = w_csr_wdata;
  assign bus.csr_rd    = w_csr_rd;
  assign bus.csr_wr    = w_csr_wr;
  assign o_busy        = w_busy;
  assign o_flush       = w_flush;
  assign o_redirect    = w_redirect;
  assign o_redirect_pc = r_redirect_pc;
  assign o_trap_cause  = r_cause;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: behavioural CSR file, architectural reference
// model, expected-response queue and a negedge monitor.
module tb_csr_trap_ctrl;
  localparam logic [31:0] MTVEC = 32'h0000_0100;
  localparam logic [31:0] C_EXT = 32'h8000_000B;
  localparam logic [31:0] C_TMR = 32'h8000_0007;

  logic        clk, rst;
  logic        ext_irq, timer_irq, mret;
  logic [31:0] pc;
  logic        busy, flush, redirect;
  logic [31:0] redirect_pc, trap_cause;

  csr_trap_ctrl_if u_if ();

  csr_trap_ctrl u_dut (
    .clk(clk), .rst(rst), .bus(u_if.slave),
    .i_ext_irq(ext_irq), .i_timer_irq(timer_irq), .i_mret(mret), .i_pc(pc),
    .o_busy(busy), .o_flush(flush), .o_redirect(redirect),
    .o_redirect_pc(redirect_pc), .o_trap_cause(trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // index 0 mstatus, 1 mie, 2 mepc, 3 mip
  function automatic int a2i(logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h304: return 1;
      12'h341: return 2;
      12'h344: return 3;
      default: return -1;
    endcase
  endfunction
  function automatic logic [11:0] i2a(int i);
    case (i)
      0: return 12'h300;
      1: return 12'h304;
      2: return 12'h341;
      default: return 12'h344;
    endcase
  endfunction

  // behavioural CSR register file (not reset by rst)
  logic [31:0] file_q [4] = '{default: 32'h0};
  logic [31:0] file_rdata;
  always_comb begin
    file_rdata = 32'h0;
    if (u_if.csr_rd && a2i(u_if.csr_addr) >= 0) file_rdata = file_q[a2i(u_if.csr_addr)];
  end
  assign u_if.csr_rdata = file_rdata;
  always @(posedge clk) if (u_if.csr_wr && a2i(u_if.csr_addr) >= 0) file_q[a2i(u_if.csr_addr)] <= u_if.csr_wdata;

  // reference model state
  logic [31:0] m_csr [4] = '{default: 32'h0};
  bit          m_masked = 0;
  logic [31:0] m_cause  = 32'h0;

  typedef struct {
    bit          redir;
    logic [31:0] data;
    int          cyc;
    bit          chk;
    logic [31:0] cause;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_err = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every grant or redirect consumes the next expected response
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (u_if.pl_gnt || redirect)) begin
      if (q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected: gnt=%b redirect=%b expected none (cycle %0d)", u_if.pl_gnt, redirect, cyc);
      end else begin
        e = q.pop_front();
        chk("kind_redirect", {31'h0, redirect}, {31'h0, e.redir});
        chk("event_cycle", 32'(cyc), 32'(e.cyc));
        if (redirect) begin
          chk("redirect_pc", redirect_pc, e.data);
          chk("trap_cause", trap_cause, e.cause);
          chk("flush", {31'h0, flush}, 32'h1);
        end else begin
          if (e.chk) chk("pl_rdata", u_if.pl_rdata, e.data);
          chk("busy_at_gnt", {31'h0, busy}, 32'h0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      if (!busy) break;
      tick();
    end
    chk("idle_reached", {31'h0, busy}, 32'h0);
    tick();
  endtask

  task automatic check_state(string tag);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_csr%0d", tag, i), file_q[i], m_csr[i]);
  endtask

  task automatic pl_op(bit wr, int i, logic [31:0] d);
    exp_t e;
    u_if.pl_req = 1'b1; u_if.pl_wr = wr; u_if.pl_addr = i2a(i); u_if.pl_wdata = d;
    e = '{redir: 0, data: m_csr[i], cyc: cyc, chk: !wr, cause: m_cause};
    q.push_back(e);
    if (wr) begin
      m_csr[i] = d;
      if (i < 2) m_masked = 0;
    end
    tick();
    u_if.pl_req = 1'b0; u_if.pl_wr = 1'b0;
  endtask

  // rising irq lines: take if MIE and an enabled source; else go masked
  task automatic irq_op(bit e_l, bit t_l, logic [31:0] p);
    exp_t e;
    logic [31:0] st;
    bit te, tt;
    int lat;
    pc = p; ext_irq = e_l; timer_irq = t_l;
    lat = m_masked ? 7 : 6;
    st = m_csr[0];
    te = e_l & m_csr[1][11];
    tt = t_l & m_csr[1][7];
    if (st[3] && (te || tt)) begin
      m_cause  = te ? C_EXT : C_TMR;
      m_csr[2] = p;
      m_csr[0] = (st & ~32'h88) | 32'h80;
      m_csr[3] = m_csr[3] | (te ? 32'h800 : 32'h80);
      m_masked = 0;
      e = '{redir: 1, data: MTVEC, cyc: cyc + lat, chk: 0, cause: m_cause};
      q.push_back(e);
    end else begin
      m_masked = 1;
    end
    tick(); tick();
    ext_irq = 1'b0; timer_irq = 1'b0;
    wait_idle();
  endtask

  function automatic void model_mret(int at);
    exp_t e;
    logic [31:0] st;
    st = m_csr[0];
    e = '{redir: 1, data: m_csr[2], cyc: at + 4, chk: 0, cause: m_cause};
    q.push_back(e);
    m_csr[0] = (st & ~32'h88) | (st[7] ? 32'h8 : 32'h0) | 32'h80;
    m_masked = 0;
  endfunction

  task automatic mret_op();
    model_mret(cyc);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bit g;
    rst = 1'b1; ext_irq = 0; timer_irq = 0; mret = 0; pc = 0;
    u_if.pl_req = 0; u_if.pl_wr = 0; u_if.pl_addr = 0; u_if.pl_wdata = 0;
    tick(); tick();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_redirect", {31'h0, redirect}, 32'h0);
    chk("rst_flush", {31'h0, flush}, 32'h0);
    chk("rst_gnt", {31'h0, u_if.pl_gnt}, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_trap_cause", trap_cause, 32'h0);
    rst = 1'b0;
    tick();

    // pipeline write then read of mie
    pl_op(1, 1, 32'h0000_0880);
    pl_op(0, 1, 32'h0);
    tick();

    // external interrupt taken
    pl_op(1, 0, 32'h8);
    pl_op(1, 1, 32'h800);
    irq_op(1, 0, 32'h0000_0040);
    check_state("ext_trap");

    // mret back to 0x40
    mret_op();
    check_state("mret");

    // disabled timer irq masks; pipeline then granted immediately
    pl_op(1, 0, 32'h0);
    irq_op(0, 1, 32'h0000_0123);
    pl_op(0, 1, 32'h0);
    pl_op(1, 0, 32'h8);
    pl_op(1, 1, 32'h80);
    irq_op(0, 1, 32'h0000_0200);
    check_state("tmr_trap");

    // mret + pl_req + ext in one IDLE cycle
    model_mret(cyc);
    e = '{redir: 0, data: m_csr[1], cyc: cyc + 5, chk: 1, cause: m_cause};
    q.push_back(e);
    mret = 1'b1; ext_irq = 1'b1;
    u_if.pl_req = 1'b1; u_if.pl_wr = 1'b0; u_if.pl_addr = 12'h304;
    tick();
    mret = 1'b0; ext_irq = 1'b0;
    g = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); g = u_if.pl_gnt;
      tick();
      if (g) break;
    end
    u_if.pl_req = 1'b0;
    chk("combo_gnt_seen", {31'h0, g}, 32'h1);
    wait_idle();
    check_state("combo");

    // reset while in WR_ST
    pl_op(1, 0, 32'h8);
    pl_op(1, 1, 32'h800);
    pc = 32'h0000_0077; ext_irq = 1'b1;
    tick(); tick();
    ext_irq = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_redirect", {31'h0, redirect}, 32'h0);
    chk("midrst_trap_cause", trap_cause, 32'h0);
    tick();
    rst = 1'b0;
    m_csr[2] = 32'h0000_0077; m_masked = 0; m_cause = 32'h0;
    tick();
    check_state("midrst");

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      int r, i;
      bit e_l, t_l;
      r = $urandom_range(0, 9);
      i = $urandom_range(0, 3);
      if (r <= 2) pl_op(1, i, $urandom);
      else if (r <= 4) pl_op(0, i, 32'h0);
      else if (r <= 7) begin
        e_l = 1'($urandom_range(0, 1));
        t_l = e_l ? 1'($urandom_range(0, 1)) : 1'b1;
        irq_op(e_l, t_l, $urandom);
      end else mret_op();
      tick();
      check_state("rnd");
    end

    tick(); tick();
    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
